gold_interaction: RTL

Per-frame interaction sensor that sits directly upstream of the gold-bag motion controller and produces its collision, side, can_fall and been_eaten inputs.
- It watches the pixel stream: gold/digger drawing-request overlap and dirt pixels in a probe row under the bag.
- It accumulates over one frame and publishes registered results at each startOfFrame.
- It also emits digger_crush and eat_pulse events toward the digger and score logic.

---
 rtl/gold_pkg.sv | 26 ++
 rtl/gold_probe_window.sv | 62 ++++++
 rtl/gold_interaction.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gold_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gold_pkg
// Purpose  : Shared encodings for the gold-bag interaction sensor.
//            Gold-bag state codes, eat-detection FSM states, cell size.
// Revision : 1.0 - initial release
// ============================================================================
package gold_pkg;

  // Bag states as reported by the motion controller
  localparam logic [3:0] GOLD_REST  = 4'd0;
  localparam logic [3:0] GOLD_FALL  = 4'd1;
  localparam logic [3:0] GOLD_CRASH = 4'd2;
  localparam logic [3:0] GOLD_EATEN = 4'd3;

  // Eat-detection FSM
  typedef enum logic [1:0] {
    WATCH = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } eat_state_t;

  localparam int CELL_SIZE = 32;

endpackage
`default_nettype wire

// File: rtl/gold_probe_window.sv
`default_nettype none
// ============================================================================
// Module   : gold_probe_window
// Purpose  : Counts undug dirt pixels in the probe row beneath the bag.
//            The probe row is goldTopLeftY + PROBE_OFFSET_Y and spans columns
//            goldTopLeftX + PROBE_X_LO .. goldTopLeftX + PROBE_X_HI.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            clear           - frame boundary; count restarts from this pixel
//            pixel_x/pixel_y - current scan position (signed)
//            gold_x/gold_y   - bag top-left (signed)
//            dirt            - undug dirt at the current pixel
//            dirt_cnt        - saturating dirt count for the current frame
//            probe_y         - probe row (12-bit signed)
// Revision : 1.0 - initial release
// ============================================================================
module gold_probe_window #(
  parameter int PROBE_OFFSET_Y = 32,
  parameter int PROBE_X_LO     = 8,
  parameter int PROBE_X_HI     = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic signed [10:0] pixel_x,
  input  logic signed [10:0] pixel_y,
  input  logic signed [10:0] gold_x,
  input  logic signed [10:0] gold_y,
  input  logic               dirt,
  output logic [4:0]         dirt_cnt,
  output logic signed [11:0] probe_y
);

  localparam logic signed [11:0] OFF_Y = 12'(PROBE_OFFSET_Y);
  localparam logic signed [11:0] X_LO  = 12'(PROBE_X_LO);
  localparam logic signed [11:0] X_HI  = 12'(PROBE_X_HI);

  // One extra bit so bag positions near the edge cannot wrap the window
  logic signed [11:0] px, py, x_lo, x_hi;
  logic               in_window;
  logic               dirt_hit;

  assign px        = {pixel_x[10], pixel_x};
  assign py        = {pixel_y[10], pixel_y};
  assign probe_y   = {gold_y[10], gold_y} + OFF_Y;
  assign x_lo      = {gold_x[10], gold_x} + X_LO;
  assign x_hi      = {gold_x[10], gold_x} + X_HI;
  assign in_window = (py == probe_y) && (px >= x_lo) && (px <= x_hi);
  assign dirt_hit  = dirt && in_window;

  always_ff @(posedge clk) begin
    if (reset) begin
      dirt_cnt <= 5'd0;
    end else if (clear) begin
      // The boundary cycle's pixel belongs to the new frame
      dirt_cnt <= dirt_hit ? 5'd1 : 5'd0;
    end else if (dirt_hit && (dirt_cnt != 5'd31)) begin
      dirt_cnt <= dirt_cnt + 5'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gold_interaction.sv
`default_nettype none
// ============================================================================
// Module   : gold_interaction
// Purpose  : Per-frame gold-bag interaction sensor. Accumulates bag/digger
//            overlap and probe-row dirt over a frame and publishes registered
//            collision/side/can_fall/been_eaten at each startOfFrame, plus the
//            digger_crush and eat_pulse one-cycle events.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            startOfFrame          - one-cycle frame-start pulse
//            pixelX, pixelY        - scan position (signed)
//            goldTopLeftX/Y        - bag position (signed)
//            diggerTopLeftX        - digger X position (signed)
//            gold_state            - 0 rest, 1 fall, 2 crash, 3 eaten
//            *DrawingRequest       - bag / digger / dirt pixel present
//            collision, side, can_fall, been_eaten - frame-level results
//            eat_pulse, digger_crush               - one-cycle events
// Revision : 1.0 - initial release
// ============================================================================
module gold_interaction
  import gold_pkg::*;
#(
  parameter int SCREEN_H       = 480,
  parameter int PROBE_OFFSET_Y = 32,
  parameter int PROBE_X_LO     = 8,
  parameter int PROBE_X_HI     = 23,
  parameter int FALL_THRESH    = 2,
  parameter int EAT_FRAMES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  input  logic signed [10:0] goldTopLeftX,
  input  logic signed [10:0] goldTopLeftY,
  input  logic signed [10:0] diggerTopLeftX,
  input  logic [3:0]         gold_state,
  input  logic               goldDrawingRequest,
  input  logic               diggerDrawingRequest,
  input  logic               dirtDrawingRequest,
  output logic               collision,
  output logic               side,
  output logic               can_fall,
  output logic               been_eaten,
  output logic               eat_pulse,
  output logic               digger_crush
);

  localparam int                 CNT_W      = $clog2(EAT_FRAMES + 1);
  localparam logic [CNT_W-1:0]   EAT_LIM    = CNT_W'(EAT_FRAMES);
  localparam logic [4:0]         FALL_LIM   = 5'(FALL_THRESH);
  localparam logic signed [11:0] SCREEN_LIM = 12'(SCREEN_H);

  logic [4:0]         dirt_cnt;
  logic signed [11:0] probe_y;

  logic hit_now, side_now;
  logic hit_acc, side_acc;

  logic is_rest, is_fall, is_crash;

  eat_state_t       state, state_n;
  logic [CNT_W-1:0] eat_cnt, eat_cnt_n;
  logic             enter_done;

  gold_probe_window #(
    .PROBE_OFFSET_Y (PROBE_OFFSET_Y),
    .PROBE_X_LO     (PROBE_X_LO),
    .PROBE_X_HI     (PROBE_X_HI)
  ) u_probe (
    .clk      (clk),
    .reset    (reset),
    .clear    (startOfFrame),
    .pixel_x  (pixelX),
    .pixel_y  (pixelY),
    .gold_x   (goldTopLeftX),
    .gold_y   (goldTopLeftY),
    .dirt     (dirtDrawingRequest),
    .dirt_cnt (dirt_cnt),
    .probe_y  (probe_y)
  );

  assign hit_now  = goldDrawingRequest & diggerDrawingRequest;
  assign side_now = {diggerTopLeftX[10], diggerTopLeftX} > {goldTopLeftX[10], goldTopLeftX};

  assign is_rest  = (gold_state == GOLD_REST);
  assign is_fall  = (gold_state == GOLD_FALL);
  assign is_crash = (gold_state == GOLD_CRASH);

  // Eat FSM next-state; only advances on a frame boundary
  always_comb begin
    state_n    = state;
    eat_cnt_n  = eat_cnt;
    enter_done = 1'b0;
    if (startOfFrame) begin
      case (state)
        WATCH: begin
          if (is_crash && hit_acc) begin
            eat_cnt_n = CNT_W'(1);
            if (EAT_FRAMES == 1) begin
              state_n    = DONE;
              enter_done = 1'b1;
            end else begin
              state_n = COUNT;
            end
          end
        end
        COUNT: begin
          if (!is_crash || !hit_acc) begin
            state_n   = WATCH;
            eat_cnt_n = '0;
          end else begin
            eat_cnt_n = eat_cnt + CNT_W'(1);
            if (eat_cnt_n == EAT_LIM) begin
              state_n    = DONE;
              enter_done = 1'b1;
            end
          end
        end
        DONE:    ;
        default: begin
          state_n   = WATCH;
          eat_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WATCH;
      eat_cnt <= '0;
    end else begin
      state   <= state_n;
      eat_cnt <= eat_cnt_n;
    end
  end

  // Accumulators and published outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_acc      <= 1'b0;
      side_acc     <= 1'b0;
      collision    <= 1'b0;
      side         <= 1'b0;
      can_fall     <= 1'b0;
      been_eaten   <= 1'b0;
      eat_pulse    <= 1'b0;
      digger_crush <= 1'b0;
    end else begin
      eat_pulse  <= enter_done;
      been_eaten <= been_eaten | enter_done;
      if (startOfFrame) begin
        collision    <= hit_acc & is_rest;
        digger_crush <= hit_acc & is_fall;
        if (hit_acc) begin
          side <= side_acc;
        end
        can_fall <= (dirt_cnt <= FALL_LIM) && (probe_y < SCREEN_LIM) && (is_rest || is_fall);
        // Re-seed with the boundary cycle's own pixel
        hit_acc <= hit_now;
        if (hit_now) begin
          side_acc <= side_now;
        end
      end else begin
        digger_crush <= 1'b0;
        hit_acc      <= hit_acc | hit_now;
        if (hit_now && !hit_acc) begin
          side_acc <= side_now;
        end
      end
    end
  end

endmodule
`default_nettype wire
